// File: rtl/sn_gen_sched.sv
// sn_gen_sched: round-robin scheduler and sequencer for the shared
// stochastic-number generator (start, 2^NUM_BIT stream cycles, stop, done).
module sn_gen_sched #(
  parameter int NUM_BIT = 8,
  parameter int DIM     = 4,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                       i_clk_sn_sched,
  input  logic                       i_rst_sn_sched,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*DIM*NUM_BIT-1:0] i_req_x,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [DIM*NUM_BIT-1:0]     o_x_bn,
  output logic                       o_start_sng,
  output logic                       o_stop_sng,
  input  logic                       i_isgen_sng,
  output logic                       o_bit_valid,
  output logic [NUM_BIT-1:0]         o_bit_idx,
  output logic [ID_W-1:0]            o_owner,
  output logic                       o_done,
  output logic                       o_busy,
  output logic                       o_err
);

  localparam int VW = DIM * NUM_BIT;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_BIT-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [VW-1:0]      x_q, x_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;

  // Cyclic search for the first valid requester after the rr pointer.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && i_req_valid[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx;
      end
    end
    if (state_q != IDLE || !i_rst_sn_sched) begin
      gnt    = '0;
      gnt_id = '0;
    end
  end

  // Next-state logic: grant/latch, start, stream count, stop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    x_d     = x_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) x_d = i_req_x[r*VW +: VW];
          end
          owner_d = gnt_id;
          ptr_d   = gnt_id;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (!i_isgen_sng) err_d = 1'b1;
        if (cnt_q == '1) state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk_sn_sched) begin
    if (!i_rst_sn_sched) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      owner_q <= '0;
      x_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      x_q     <= x_d;
      err_q   <= err_d;
    end
  end

  assign o_req_ready = gnt;
  assign o_x_bn      = x_q;
  assign o_start_sng = (state_q == START);
  assign o_stop_sng  = (state_q == STOP);
  assign o_done      = (state_q == STOP);
  assign o_bit_valid = (state_q == RUN);
  assign o_bit_idx   = (state_q == RUN) ? cnt_q : '0;
  assign o_owner     = owner_q;
  assign o_busy      = (state_q != IDLE);
  assign o_err       = err_q;

endmodule

// File: tb/tb_sn_gen_sched.sv
// tb_sn_gen_sched: random and directed stimulus for sn_gen_sched,
// checked every cycle against a job-timeline model.
module tb_sn_gen_sched;

  localparam int NB  = 8;
  localparam int DIM = 4;
  localparam int NR  = 2;
  localparam int IDW = 1;
  localparam int VW  = NB * DIM;
  localparam int L   = 1 << NB;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     valid = '0;
  logic [NR*VW-1:0]  xin = '0;
  logic              isgen = 1'b1;
  logic [NR-1:0]     ready;
  logic [VW-1:0]     x_bn;
  logic              start_o, stop_o, bvalid, done, busy, err;
  logic [NB-1:0]     bidx;
  logic [IDW-1:0]    owner;

  int n_cmp = 0;
  int n_bad = 0;

  int m_k = 0;
  int m_ptr = NR - 1;
  int m_owner = 0;
  logic [VW-1:0] m_x = '0;
  logic m_err = 1'b0;

  int glog[$];
  int dlog[$];
  int run_len = 0;
  int last_run = 0;

  sn_gen_sched #(.NUM_BIT(NB), .DIM(DIM), .NUM_REQ(NR), .ID_W(IDW)) dut (
    .i_clk_sn_sched(clk),
    .i_rst_sn_sched(rst),
    .i_req_valid(valid),
    .i_req_x(xin),
    .o_req_ready(ready),
    .o_x_bn(x_bn),
    .o_start_sng(start_o),
    .o_stop_sng(stop_o),
    .i_isgen_sng(isgen),
    .o_bit_valid(bvalid),
    .o_bit_idx(bidx),
    .o_owner(owner),
    .o_done(done),
    .o_busy(busy),
    .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic logic [NR-1:0] arb(input int ptr, input logic [NR-1:0] v);
    for (int i = 1; i <= NR; i++) begin
      int r;
      r = (ptr + i) % NR;
      if (v[r]) return NR'(1) << r;
    end
    return '0;
  endfunction

  // Model: m_k counts cycles since the handshake (0 = idle),
  // 1 = start, 2..L+1 = stream bits, L+2 = stop/done.
  initial begin
    logic [NR-1:0] er;
    @(posedge clk);
    forever begin
      @(negedge clk);
      er = (rst && m_k == 0) ? arb(m_ptr, valid) : '0;
      chk("ready", 64'(ready), 64'(er));
      chk("start", 64'(start_o), 64'(m_k == 1));
      chk("bit_valid", 64'(bvalid), 64'(m_k >= 2 && m_k <= L + 1));
      chk("bit_idx", 64'(bidx),
          (m_k >= 2 && m_k <= L + 1) ? 64'(m_k - 2) : 64'd0);
      chk("stop", 64'(stop_o), 64'(m_k == L + 2));
      chk("done", 64'(done), 64'(m_k == L + 2));
      chk("busy", 64'(busy), 64'(m_k != 0));
      chk("owner", 64'(owner), 64'(m_owner));
      chk("x_bn", 64'(x_bn), 64'(m_x));
      chk("err", 64'(err), 64'(m_err));
      if (rst) begin
        for (int r = 0; r < NR; r++)
          if (ready[r] && valid[r]) glog.push_back(r);
        if (bvalid) run_len++;
        if (done) begin
          last_run = run_len;
          run_len = 0;
          dlog.push_back(int'(owner));
        end
      end else begin
        run_len = 0;
      end
      if (!rst) begin
        m_k = 0;
        m_ptr = NR - 1;
        m_owner = 0;
        m_x = '0;
        m_err = 1'b0;
      end else begin
        if (m_k >= 2 && m_k <= L + 1 && !isgen) m_err = 1'b1;
        if (m_k == 0) begin
          for (int r = 0; r < NR; r++) begin
            if (er[r]) begin
              m_k = 1;
              m_owner = r;
              m_ptr = r;
              m_x = xin[r*VW +: VW];
            end
          end
        end else if (m_k == L + 2) begin
          m_k = 0;
        end else begin
          m_k++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  task automatic wait_glog(input int n, input int budget);
    int c;
    c = 0;
    while (glog.size() < n) begin
      @(negedge clk);
      #1;
      if (++c > budget) begin
        timeout("grant");
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy && cyc < budget);
    if (busy) timeout("idle");
  endtask

  task automatic wait_idx(input int idx);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(bvalid && int'(bidx) == idx) && c < 600);
    if (!(bvalid && int'(bidx) == idx)) timeout("bit_idx");
  endtask

  initial begin
    int g0, d0, cyc;
    logic [NR-1:0] hs;

    do_reset();
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_x", 64'(x_bn), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // single job, requester 0, operands 1,2,3,4
    step();
    xin[VW-1:0] = 32'h04030201;
    valid = 2'b01;
    g0 = glog.size();
    wait_glog(g0 + 1, 10);
    step();
    valid = '0;
    wait_idle(400, cyc);
    chk("period", 64'(cyc), 64'd259);
    chk("runlen", 64'(last_run), 64'd256);
    chk("done_owner0", 64'(dlog[dlog.size()-1]), 64'd0);
    chk("x_latched", 64'(x_bn), 64'h04030201);

    // round robin, both requesters valid continuously
    step();
    do_reset();
    xin = {32'hdeadbeef, 32'h12345678};
    valid = 2'b11;
    g0 = glog.size();
    d0 = dlog.size();
    wait_glog(g0 + 4, 4 * 270);
    @(posedge clk);
    #1;
    valid = '0;
    wait_idle(400, cyc);
    if (glog.size() >= g0 + 4) begin
      chk("rr_g0", 64'(glog[g0]), 64'd0);
      chk("rr_g1", 64'(glog[g0+1]), 64'd1);
      chk("rr_g2", 64'(glog[g0+2]), 64'd0);
      chk("rr_g3", 64'(glog[g0+3]), 64'd1);
    end
    chk("rr_dcount", 64'(dlog.size() - d0), 64'd4);
    if (dlog.size() >= d0 + 4) begin
      chk("rr_d1", 64'(dlog[d0+1]), 64'd1);
      chk("rr_d2", 64'(dlog[d0+2]), 64'd0);
    end

    // late arrival of requester 1 during requester 0's run
    step();
    do_reset();
    valid = 2'b01;
    g0 = glog.size();
    wait_glog(g0 + 1, 10);
    wait_idx(5);
    step();
    valid = 2'b11;
    wait_glog(g0 + 2, 300);
    step();
    valid = '0;
    if (glog.size() >= g0 + 2)
      chk("late_g", 64'(glog[g0+1]), 64'd1);
    wait_idle(400, cyc);

    // reset in the middle of a job
    step();
    do_reset();
    valid = 2'b01;
    g0 = glog.size();
    wait_glog(g0 + 1, 10);
    step();
    valid = '0;
    wait_idx(99);
    d0 = dlog.size();
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_valid", 64'(bvalid), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_x", 64'(x_bn), 64'd0);
    step();
    rst = 1'b1;
    valid = 2'b11;
    g0 = glog.size();
    wait_glog(g0 + 1, 10);
    step();
    valid = '0;
    if (glog.size() >= g0 + 1)
      chk("mid_prio", 64'(glog[g0]), 64'd0);
    wait_idle(400, cyc);
    chk("mid_dcount", 64'(dlog.size() - d0), 64'd1);

    // generator drops "generating" for one run cycle
    step();
    do_reset();
    valid = 2'b01;
    g0 = glog.size();
    d0 = dlog.size();
    wait_glog(g0 + 1, 10);
    step();
    valid = '0;
    wait_idx(49);
    step();
    isgen = 1'b0;
    step();
    isgen = 1'b1;
    wait_idle(400, cyc);
    chk("isgen_err", 64'(err), 64'd1);
    chk("isgen_run", 64'(last_run), 64'd256);
    chk("isgen_done", 64'(dlog.size() - d0), 64'd1);
    repeat (5) step();
    @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);

    // randomized traffic
    step();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      hs = valid & ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (valid[r] && !hs[r]) begin
          if ($urandom_range(0, 15) == 0) valid[r] = 1'b0;
        end else begin
          valid[r] = ($urandom_range(0, 2) == 0);
          xin[r*VW +: VW] = $urandom;
        end
      end
      isgen = ($urandom_range(0, 299) != 0);
    end
    valid = '0;
    isgen = 1'b1;
    wait_idle(400, cyc);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
